if_stage: RTL

Instruction-fetch stage with integrated IF/ID pipeline register. Owns the PC, issues one instruction-memory request per cycle and absorbs memory stalls, downstream stalls and branch/jump redirects. Presents the fetched word and its decoded Opcode/Funct3/Funct7/register fields to the decode stage, where they drive the control unit directly.

---
 rtl/if_stage_pkg.sv | 37 +++
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage_if_id_reg.sv | 76 +++++++
 rtl/if_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
// Definitions shared by the fetch stage and the decode-side control unit:
//   - opcode_e     : major opcode constants (R_Type .. UJ_Type_JALR)
//   - NOP_INSTR    : canonical bubble encoding (addi x0, x0, 0)
//   - *_MSB/*_LSB  : bit positions of the decoded instruction fields
// ----------------------------------------------------------------------------
package if_stage_pkg;

  typedef enum logic [6:0] {
    R_Type       = 7'b0110011,
    I_Type       = 7'b0010011,
    I_Type_Load  = 7'b0000011,
    S_Type       = 7'b0100011,
    SB_Type      = 7'b1100011,
    U_Type_LUI   = 7'b0110111,
    U_Type_AUIPC = 7'b0010111,
    UJ_Type_JAL  = 7'b1101111,
    UJ_Type_JALR = 7'b1100111
  } opcode_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

endpackage

// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if
// Instruction-memory request bus between the fetch stage and memory.
//   imem_req   : fetch request            (master -> slave)
//   imem_addr  : word-aligned byte address (master -> slave)
//   imem_rdata : instruction word          (slave -> master)
//   imem_stall : memory busy, hold request (slave -> master)
// ----------------------------------------------------------------------------
interface if_stage_if #(
  parameter int BITS = 32
) ();
  logic            imem_req;
  logic [BITS-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_stall;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_stall
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_stall
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register plus a one-entry hold buffer that parks a word
// fetched while decode was stalled.
//   clk, rst   : clock, asynchronous active-high reset
//   i_load     : IF/ID <- {1, i_pc, i_instr}
//   i_capture  : hold buffer <- {i_pc, i_instr}; IF/ID unchanged
//   i_release  : IF/ID <- hold buffer; buffer emptied
//   i_flush    : IF/ID <- bubble; hold buffer emptied
//   i_bubble   : IF/ID <- bubble
//   o_valid/o_pc/o_instr : IF/ID contents (o_instr is NOP when invalid)
// Controls are mutually exclusive in normal use; flush takes priority.
// ----------------------------------------------------------------------------
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_capture,
  input  logic            i_release,
  input  logic            i_flush,
  input  logic            i_bubble,
  input  logic [BITS-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic            o_valid,
  output logic [BITS-1:0] o_pc,
  output logic [31:0]     o_instr
);

  logic            r_valid;
  logic [BITS-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_hold_valid;
  logic [BITS-1:0] r_hold_pc;
  logic [31:0]     r_hold_instr;

  // A bubble keeps the last PC so id_pc only moves with real instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_instr      <= NOP_INSTR;
      r_hold_valid <= 1'b0;
      r_hold_pc    <= '0;
      r_hold_instr <= NOP_INSTR;
    end else if (i_flush) begin
      r_valid      <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_hold_valid <= 1'b0;
    end else if (i_release) begin
      r_valid      <= r_hold_valid;
      r_pc         <= r_hold_pc;
      r_instr      <= r_hold_valid ? r_hold_instr : NOP_INSTR;
      r_hold_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_capture) begin
      r_hold_valid <= 1'b1;
      r_hold_pc    <= i_pc;
      r_hold_instr <= i_instr;
    end else if (i_bubble) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction fetch with integrated IF/ID register. Owns the PC, issues one
// request per cycle and absorbs memory stalls, decode stalls and redirects.
//   clk, rst          : clock, asynchronous active-high reset
//   imem              : instruction-memory bus (master side)
//   i_id_stall        : decode cannot accept, hold IF/ID
//   i_redirect_valid  : taken branch/jump
//   i_redirect_pc     : redirect target (low two bits ignored)
//   o_id_valid/o_id_pc/o_id_instr : IF/ID contents
//   o_opcode .. o_rd  : bit-slices of o_id_instr for the control unit
// ----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  if_stage_if.master      imem,
  input  logic            i_id_stall,
  input  logic            i_redirect_valid,
  input  logic [BITS-1:0] i_redirect_pc,
  output logic            o_id_valid,
  output logic [BITS-1:0] o_id_pc,
  output logic [31:0]     o_id_instr,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd
);

  // FETCH: request outstanding; HOLD: word parked, no request;
  // DROP: redirected while memory busy, waiting to discard the old word.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t          r_state, w_state_next;
  logic [BITS-1:0] r_pc, w_pc_next;
  logic [BITS-1:0] r_target, w_target_next;
  logic [BITS-1:0] w_redirect_tgt;
  logic            w_req;
  logic            w_load, w_capture, w_release, w_flush, w_bubble;
  logic [31:0]     w_id_instr;

  assign w_redirect_tgt = i_redirect_pc & ~BITS'(3);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_target <= RESET_PC;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_target <= w_target_next;
    end
  end

  // Next-state and PC
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_target_next = r_target;
    unique case (r_state)
      S_FETCH: begin
        if (i_redirect_valid) begin
          // Memory still busy: the address must stay put, so park the target.
          if (imem.imem_stall) begin
            w_state_next  = S_DROP;
            w_target_next = w_redirect_tgt;
          end else begin
            w_pc_next = w_redirect_tgt;
          end
        end else if (!imem.imem_stall) begin
          w_pc_next = r_pc + BITS'(4);
          if (i_id_stall) w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_redirect_valid) begin
          w_pc_next    = w_redirect_tgt;
          w_state_next = S_FETCH;
        end else if (!i_id_stall) begin
          w_state_next = S_FETCH;
        end
      end
      S_DROP: begin
        if (!imem.imem_stall) begin
          w_pc_next    = i_redirect_valid ? w_redirect_tgt : r_target;
          w_state_next = S_FETCH;
        end else if (i_redirect_valid) begin
          w_target_next = w_redirect_tgt;
        end
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  // Outputs: memory request and IF/ID controls
  always_comb begin
    w_req     = !rst && (r_state != S_HOLD);
    w_load    = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    w_flush   = 1'b0;
    w_bubble  = 1'b0;
    // IF/ID stays empty for the whole DROP window.
    if (i_redirect_valid || r_state == S_DROP) begin
      w_flush = 1'b1;
    end else if (r_state == S_FETCH) begin
      if (!imem.imem_stall) begin
        w_load    = !i_id_stall;
        w_capture = i_id_stall;
      end else begin
        w_bubble = !i_id_stall;
      end
    end else if (r_state == S_HOLD) begin
      w_release = !i_id_stall;
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  if_id_reg #(
    .BITS(BITS)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_capture(w_capture),
    .i_release(w_release),
    .i_flush  (w_flush),
    .i_bubble (w_bubble),
    .i_pc     (r_pc),
    .i_instr  (imem.imem_rdata),
    .o_valid  (o_id_valid),
    .o_pc     (o_id_pc),
    .o_instr  (w_id_instr)
  );

  assign o_id_instr = w_id_instr;
  assign o_opcode   = w_id_instr[OPCODE_MSB:OPCODE_LSB];
  assign o_funct3   = w_id_instr[FUNCT3_MSB:FUNCT3_LSB];
  assign o_funct7   = w_id_instr[FUNCT7_MSB:FUNCT7_LSB];
  assign o_rs1      = w_id_instr[RS1_MSB:RS1_LSB];
  assign o_rs2      = w_id_instr[RS2_MSB:RS2_LSB];
  assign o_rd       = w_id_instr[RD_MSB:RD_LSB];

endmodule
